// File: rtl/coco_kbd_pkg.sv
// Shared constants and types for the CoCo keyboard matrix: dimensions,
// matrix-position encoding and the PS/2 set-2 scancodes given special handling.
package coco_kbd_pkg;

  localparam int ROWS = 7;
  localparam int COLS = 8;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_F1     = 8'h05;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_APOS   = 8'h52;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_HOME   = 8'h6C;

  localparam logic [2:0] SHIFT_ROW = 3'd6;
  localparam logic [2:0] SHIFT_COL = 3'd7;
  localparam int         SHIFT_POS = 55;

  function automatic key_pos_t kpos(input logic [2:0] row, input logic [2:0] col);
    return '{hit: 1'b1, row: row, col: col};
  endfunction

endpackage

// File: rtl/coco_keyboard_if.sv
// Keyboard-side bundle between the HPS feed / PIA0 port and coco_keyboard.
interface coco_keyboard_if;
  import coco_kbd_pkg::*;

  logic [10:0]          ps2_key;
  logic                 kb_clear;
  logic [COLS-1:0]      col_strobe;
  logic [1:0]           joy_btn;
  logic [ROWS-1:0]      row_sense;
  logic                 key_event;
  logic [ROWS*COLS-1:0] matrix_dbg;

  modport master (
    output ps2_key, kb_clear, col_strobe, joy_btn,
    input  row_sense, key_event, matrix_dbg
  );

  modport slave (
    input  ps2_key, kb_clear, col_strobe, joy_btn,
    output row_sense, key_event, matrix_dbg
  );
endinterface

// File: rtl/coco_scancode_rom.sv
// Combinational {extended, scancode} -> CoCo matrix position lookup.
module coco_scancode_rom
  import coco_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output key_pos_t   pos
);

  always_comb begin
    pos = '0;
    if (ext) begin
      // Arrows and Home exist only as E0-prefixed codes
      case (code)
        SC_UP:    pos = kpos(3'd3, 3'd3);
        SC_DOWN:  pos = kpos(3'd3, 3'd4);
        SC_LEFT:  pos = kpos(3'd3, 3'd5);
        SC_RIGHT: pos = kpos(3'd3, 3'd6);
        SC_HOME:  pos = kpos(3'd6, 3'd1);
        default:  pos = '0;
      endcase
    end else begin
      case (code)
        8'h1C: pos = kpos(3'd0, 3'd1);
        8'h32: pos = kpos(3'd0, 3'd2);
        8'h21: pos = kpos(3'd0, 3'd3);
        8'h23: pos = kpos(3'd0, 3'd4);
        8'h24: pos = kpos(3'd0, 3'd5);
        8'h2B: pos = kpos(3'd0, 3'd6);
        8'h34: pos = kpos(3'd0, 3'd7);
        8'h33: pos = kpos(3'd1, 3'd0);
        8'h43: pos = kpos(3'd1, 3'd1);
        8'h3B: pos = kpos(3'd1, 3'd2);
        8'h42: pos = kpos(3'd1, 3'd3);
        8'h4B: pos = kpos(3'd1, 3'd4);
        8'h3A: pos = kpos(3'd1, 3'd5);
        8'h31: pos = kpos(3'd1, 3'd6);
        8'h44: pos = kpos(3'd1, 3'd7);
        8'h4D: pos = kpos(3'd2, 3'd0);
        8'h15: pos = kpos(3'd2, 3'd1);
        8'h2D: pos = kpos(3'd2, 3'd2);
        8'h1B: pos = kpos(3'd2, 3'd3);
        8'h2C: pos = kpos(3'd2, 3'd4);
        8'h3C: pos = kpos(3'd2, 3'd5);
        8'h2A: pos = kpos(3'd2, 3'd6);
        8'h1D: pos = kpos(3'd2, 3'd7);
        8'h22: pos = kpos(3'd3, 3'd0);
        8'h35: pos = kpos(3'd3, 3'd1);
        8'h1A: pos = kpos(3'd3, 3'd2);
        SC_BKSP:  pos = kpos(3'd3, 3'd5);
        SC_SPACE: pos = kpos(3'd3, 3'd7);
        8'h45: pos = kpos(3'd4, 3'd0);
        8'h16: pos = kpos(3'd4, 3'd1);
        8'h1E: pos = kpos(3'd4, 3'd2);
        8'h26: pos = kpos(3'd4, 3'd3);
        8'h25: pos = kpos(3'd4, 3'd4);
        8'h2E: pos = kpos(3'd4, 3'd5);
        8'h36: pos = kpos(3'd4, 3'd6);
        8'h3D: pos = kpos(3'd4, 3'd7);
        8'h3E: pos = kpos(3'd5, 3'd0);
        8'h46: pos = kpos(3'd5, 3'd1);
        SC_APOS: pos = kpos(3'd5, 3'd2);
        8'h4C: pos = kpos(3'd5, 3'd3);
        8'h41: pos = kpos(3'd5, 3'd4);
        8'h4E: pos = kpos(3'd5, 3'd5);
        8'h49: pos = kpos(3'd5, 3'd6);
        8'h4A: pos = kpos(3'd5, 3'd7);
        SC_ENTER:  pos = kpos(3'd6, 3'd0);
        SC_F1:     pos = kpos(3'd6, 3'd1);
        SC_ESC:    pos = kpos(3'd6, 3'd2);
        SC_LSHIFT: pos = kpos(SHIFT_ROW, SHIFT_COL);
        SC_RSHIFT: pos = kpos(SHIFT_ROW, SHIFT_COL);
        default:   pos = '0;
      endcase
    end
  end

endmodule

// File: rtl/coco_keyboard.sv
// PS/2 event stream -> CoCo 7x8 key matrix, answering PIA0 column scans
// with active-low row sense (joystick fire merged onto PA0/PA1).
module coco_keyboard
  import coco_kbd_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  coco_keyboard_if.slave kbd
);

  logic                 primed, toggle_ref;
  logic                 vld_p0;
  logic [9:0]           key_p0;
  logic                 vld_p1, pressed_p1, lsh_p1, rsh_p1;
  key_pos_t             pos_p1, rom_pos;
  logic [ROWS*COLS-1:0] matrix;
  logic                 lshift, rshift, key_event;
  logic [ROWS-1:0]      row_sense, sel, joy_ext;

  // Stage 0: detect a toggle on bit 10; the first sample after reset only primes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      primed     <= 1'b0;
      toggle_ref <= 1'b0;
      vld_p0     <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      if (!primed) begin
        primed     <= 1'b1;
        toggle_ref <= kbd.ps2_key[10];
      end else if (kbd.ps2_key[10] != toggle_ref) begin
        toggle_ref <= kbd.ps2_key[10];
        vld_p0     <= ~kbd.kb_clear;
      end
    end
  end

  always_ff @(posedge clk) key_p0 <= kbd.ps2_key[9:0];

  coco_scancode_rom u_rom (
    .ext  (key_p0[8]),
    .code (key_p0[7:0]),
    .pos  (rom_pos)
  );

  // Stage 1: registered decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0 & ~kbd.kb_clear;
  end

  always_ff @(posedge clk) begin
    pos_p1     <= rom_pos;
    pressed_p1 <= key_p0[9];
    lsh_p1     <= ~key_p0[8] && (key_p0[7:0] == SC_LSHIFT);
    rsh_p1     <= ~key_p0[8] && (key_p0[7:0] == SC_RSHIFT);
  end

  // Stage 2: matrix update; SHIFT is the OR of both physical shift keys
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      matrix    <= '0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      key_event <= 1'b0;
    end else if (kbd.kb_clear) begin
      matrix    <= '0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      key_event <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (vld_p1 && pos_p1.hit) begin
        key_event <= 1'b1;
        if (lsh_p1) begin
          lshift            <= pressed_p1;
          matrix[SHIFT_POS] <= pressed_p1 | rshift;
        end else if (rsh_p1) begin
          rshift            <= pressed_p1;
          matrix[SHIFT_POS] <= pressed_p1 | lshift;
        end else begin
          matrix[{pos_p1.row, pos_p1.col}] <= pressed_p1;
        end
      end
    end
  end

  assign joy_ext = {{(ROWS-2){1'b0}}, kbd.joy_btn};

  always_comb begin
    sel = '0;
    for (int r = 0; r < ROWS; r++)
      sel[r] = |(matrix[r*COLS +: COLS] & ~kbd.col_strobe) | joy_ext[r];
  end

  // Stage 3: registered row sense
  always_ff @(posedge clk or posedge reset) begin
    if (reset) row_sense <= '1;
    else       row_sense <= ~sel;
  end

  assign kbd.row_sense  = row_sense;
  assign kbd.key_event  = key_event;
  assign kbd.matrix_dbg = matrix;

endmodule

// File: doc/coco_keyboard.md
Name: coco_keyboard

Overview:
- Converts MiSTer `ps2_key` events into the CoCo 7x8 keyboard matrix.
- Answers PIA0 column-strobe scans with active-low row-sense data.
- Merges the two joystick fire buttons onto PA0/PA1.
- Sits between the HPS keyboard feed and the PIA0 port-A input inside the CoCo core; replaces ad-hoc key decode in the system block.

Parameters:
- ROWS, 7, matrix rows (PA0..PA6).
- COLS, 8, matrix columns (PB0..PB7).

Ports:
- clk  in  1  system clock (57.272 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- ps2_key  in  11  [10] toggle per event, [9] pressed, [8] extended, [7:0] scancode.
- kb_clear  in  1  level; releases all keys while high (driven from ioctl_download).
- col_strobe  in  8  PIA0 PB output; active-low column select.
- joy_btn  in  2  fire buttons, active-high; [0] right, [1] left.
- row_sense  out  7  PIA0 PA[6:0]; active-low, registered.
- key_event  out  1  one-cycle pulse when a mapped key changes matrix state.
- matrix_dbg  out  56  current matrix, bit index row*8+col, 1 = held.

Behaviour:
- Reset values: matrix 0; shift flags 0; row_sense 7'h7F; key_event 0; primed 0.
- Stage 0 (edge E0): register ps2_key.
  - If primed=0: copy bit10 to toggle_ref, set primed, no event. Prevents a phantom key after reset.
  - If primed=1 and bit10 != toggle_ref: event_valid, update toggle_ref.
- Stage 1 (E1): decode {extended, scancode} through the scancode ROM to {hit, row[2:0], col[2:0]}; register with pressed.
- Stage 2 (E2): if hit, matrix[row*8+col] <= pressed and key_event pulses for exactly one cycle. The pulse is asserted even if the bit is already at that value.
- Stage 3 (E3): row_sense registered. Net latency: 3 edges from first ps2_key sample to row_sense.
- Shift handling:
  - L-shift 0x12 and R-shift 0x59 set or clear separate flags.
  - matrix SHIFT (row6,col7) = lshift | rshift, so releasing one shift while the other is held keeps SHIFT asserted.
- Mapping:
  - Row0 @ A-G; row1 H-O; row2 P-W.
  - Row3: X Y Z UP DOWN LEFT RIGHT SPACE.
  - Row4: 0-7; row5: 8 9 : ; , - . /.
  - Row6: ENTER CLEAR BREAK x x x x SHIFT.
  - Aliases: ESC -> BREAK; Home (ext 0x6C) and F1 -> CLEAR; Backspace -> LEFT.
  - Arrows use extended codes only (E0 75/72/6B/74). Non-extended 0x75 (keypad 8) is unmapped.
  - Apostrophe -> ':'.
- Unmapped code: no matrix change, no key_event, toggle_ref still advances.
- Row sense: row_sense[r] <= ~( |(matrix[r][7:0] & ~col_strobe) | (r<2 ? joy_btn[r] : 0) ).
  - col_strobe 8'hFF with no fire button gives 7'h7F.
  - Multiple strobes low: OR of all selected columns (ghosting not modelled).
- kb_clear:
  - While high: matrix and shift flags forced 0 each cycle; stages 1/2 writes suppressed.
  - An event coinciding with kb_clear is dropped, but toggle_ref still tracks.
  - No key_event while high.
- Reset mid-pipeline: all stages flushed; primed cleared, so the next sample re-primes.
- Back-to-back events on consecutive cycles are each handled; the pipeline has no stall.

Decomposition:
- Package coco_kbd_pkg holds:
  - ROWS/COLS constants.
  - Typedef key_pos_t {hit, row[2:0], col[2:0]}.
  - Named scancode constants (SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_ESC=8'h76, ...).
  - SHIFT_POS = row6/col7.
- One sub-module: coco_scancode_rom. Purely combinational {ext, code} -> key_pos_t case table; reused by the test bench for expected values.

Test Plan:
1. Reset, then ps2_key={1,1,0,8'h1C} ('A') held static -> no event (priming). Toggle bit10 with pressed=1 -> key_event at E2; matrix_dbg[1]=1; col_strobe=8'hFD gives row_sense=7'h7E at E3; col_strobe=8'hFE gives 7'h7F.
2. Press L-shift, press R-shift, release L-shift -> matrix_dbg[55] stays 1. Release R-shift -> matrix_dbg[55]=0; row_sense[6]=1 with col_strobe=8'h7F.
3. Extended 0x75 press -> UP (row3,col3), matrix_dbg[27]=1. Non-extended 0x75 press -> no key_event, matrix unchanged.
4. Hold 'A', 'Z', ENTER, then pulse kb_clear coincident with an ESC press event -> matrix_dbg=0, no key_event. Next event after kb_clear low is processed normally.
5. joy_btn=2'b01, col_strobe=8'hFF -> row_sense=7'h7E. joy_btn=2'b10 -> 7'h7D. Both -> 7'h7C.
6. Two toggle events on consecutive cycles ('1' press, '2' press) -> two key_event pulses one cycle apart; matrix_dbg[33] and [34] both set. Asserting reset between them -> matrix 0 and row_sense 7'h7F immediately.
